bp_me_cache_dma_to_cce: RTL and testbench
=========================================

// Module: bp_me_cache_dma_to_cce
// PURPOSE
// - Memory-side adapter directly downstream of the L2 (bsg_cache) in the BedRock memory path.
// - Converts bsg_cache DMA requests (fill/evict) into block-sized BedRock mem commands and
//   converts BedRock mem responses back into the cache's beat-serial DMA data streams.
// - One transaction outstanding at a time; block = cce_block_width_p, beat = dword_width_gp.
// PARAMETERS
// - bp_params_p   e_bp_default_cfg  proc config; gives paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p
// - lce_id_p      0                 value driven in mem_cmd payload.lce_id
// - beats_lp      cce_block_width_p/dword_width_gp (local)  beats per block (8 for default cfg)
// PORTS
// - clk_i            in   1          clock
// - reset_i          in   1          reset, asynchronous, active-high
// - dma_pkt_i        in   bsg_cache_dma_pkt_width(paddr_width_p)  {write_not_read, addr}
// - dma_pkt_v_i      in   1          DMA request valid
// - dma_pkt_yumi_o   out  1          DMA request consumed
// - dma_data_o       out  dword_width_gp  fill data beat to cache
// - dma_data_v_o     out  1          fill beat valid
// - dma_data_ready_i in   1          cache accepts fill beat
// - dma_data_i       in   dword_width_gp  evict data beat from cache
// - dma_data_v_i     in   1          evict beat valid
// - dma_data_yumi_o  out  1          evict beat consumed
// - mem_cmd_o        out  cce_mem_msg_width_lp  BedRock mem command (header + block data)
// - mem_cmd_v_o      out  1          command valid
// - mem_cmd_ready_i  in   1          downstream ready (valid->ready)
// - mem_resp_i       in   cce_mem_msg_width_lp  BedRock mem response
// - mem_resp_v_i     in   1          response valid
// - mem_resp_yumi_o  out  1          response consumed
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, beat counter=0; all v/yumi outputs 0; data regs not reset.
// - IDLE: dma_pkt_yumi_o = dma_pkt_v_i; latch addr with low log2(cce_block_width_p/8) bits forced 0,
//   latch write_not_read. write -> WR_COLLECT; read -> CMD_SEND.
// - WR_COLLECT: dma_data_yumi_o = dma_data_v_i; beat k stored in block slice k (beat 0 = lowest addr);
//   counter increments per beat; after beat beats_lp-1 counter wraps to 0 -> CMD_SEND.
// - CMD_SEND: mem_cmd_v_o=1; header.msg_type = e_bedrock_mem_wr (write) / e_bedrock_mem_rd (read),
//   size = e_bedrock_msg_size_64, addr = latched aligned addr, payload.lce_id = lce_id_p, data = block
//   (0 for reads). Header/data stable while v high. v&ready -> RESP_WAIT (same edge; v drops next cycle).
// - RESP_WAIT: mem_resp_yumi_o = mem_resp_v_i. write: on consume -> IDLE. read: latch mem_resp_i.data,
//   -> RD_STREAM. Responses never consumed outside RESP_WAIT.
// - RD_STREAM: dma_data_v_o=1, dma_data_o = block slice[counter]; v&ready -> counter+1;
//   last beat accepted -> counter=0, IDLE.
// - Latency: read pkt accept -> mem_cmd_v_o next cycle; resp consume -> first fill beat next cycle.
//   Write: last evict beat -> mem_cmd_v_o next cycle.
// - dma_pkt_v_i held while busy is not consumed (no queuing). dma_data_v_i outside WR_COLLECT ignored.
// - Simultaneous mem_resp_v_i with mem_cmd handshake: response not taken until the following cycle.
// - Assertions: resp msg_type matches issued cmd; resp addr == issued addr; beats_lp power of 2, >=1.
// - Reset mid-operation: transaction dropped; partially collected data discarded; no output glitch.
// STRUCTURE
// - Package bp_me_pkg: none new; uses bedrock msg type/size enums and bp_bedrock_cce_mem_msg_s macros.
//   bsg_cache_dma_pkt_s from bsg_cache_pkg. State enum local (IDLE, WR_COLLECT, CMD_SEND, RESP_WAIT, RD_STREAM).
// - Sub-module: bsg_serial_in_parallel_out_full (width dword_width_gp, els beats_lp) for evict
//   collection; fill serialization via counter-indexed mux on a local block register.
// TESTING (default cfg: 512b block, 64b beat, 8 beats)
// - Read fill: pkt {rd, 0x8000_0040} -> mem_cmd rd size_64 addr 0x8000_0040; resp data d7..d0 ->
//   8 fill beats d0..d7 in order, then IDLE.
// - Write evict: pkt {wr, 0x8000_1008} + beats 0x11..0x88 -> mem_cmd wr addr 0x8000_1000,
//   data {0x88,...,0x11}; wr resp consumed -> IDLE, no fill beats.
// - Backpressure: mem_cmd_ready_i low 5 cycles, dma_data_ready_i toggling 1/0 -> cmd held stable,
//   every fill beat delivered exactly once, order preserved.
// - Busy: second dma_pkt_v_i during RD_STREAM -> dma_pkt_yumi_o=0 until IDLE, then consumed next cycle.
// - Async reset asserted mid WR_COLLECT (after 3 beats) -> outputs 0 immediately; new read after
//   release completes normally with counter starting at 0.
// - Early response: mem_resp_v_i=1 while in WR_COLLECT -> mem_resp_yumi_o stays 0.

Source files
------------

// File: rtl/bp_me_cache_dma_to_cce_pkg.sv
// Shared types for the cache-DMA to BedRock mem adapter: config widths, DMA packet, mem message.
package bp_me_cache_dma_to_cce_pkg;

   localparam int unsigned paddr_width_gp        = 40;
   localparam int unsigned cce_block_width_gp    = 512;
   localparam int unsigned dword_width_gp        = 64;
   localparam int unsigned lce_id_width_gp       = 4;
   localparam int unsigned beats_gp              = cce_block_width_gp / dword_width_gp;
   localparam int unsigned beat_cnt_width_gp     = (beats_gp > 1) ? $clog2(beats_gp) : 1;
   localparam int unsigned block_offset_width_gp = $clog2(cce_block_width_gp / 8);

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic                      write_not_read;
      logic [paddr_width_gp-1:0] addr;
   } bsg_cache_dma_pkt_s;

   localparam int unsigned dma_pkt_width_gp = $bits(bsg_cache_dma_pkt_s);

   typedef struct packed {
      logic [lce_id_width_gp-1:0] lce_id;
   } bp_bedrock_cce_mem_payload_s;

   typedef struct packed {
      bp_bedrock_cce_mem_payload_s payload;
      bp_bedrock_msg_size_e        size;
      logic [paddr_width_gp-1:0]   addr;
      bp_bedrock_mem_type_e        msg_type;
   } bp_bedrock_cce_mem_header_s;

   typedef struct packed {
      logic [cce_block_width_gp-1:0] data;
      bp_bedrock_cce_mem_header_s    header;
   } bp_bedrock_cce_mem_msg_s;

   localparam int unsigned mem_msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

   // Clear the byte-offset bits so the address names the whole block.
   function automatic logic [paddr_width_gp-1:0] block_align(input logic [paddr_width_gp-1:0] addr);
      return addr & ~paddr_width_gp'((cce_block_width_gp / 8) - 1);
   endfunction

endpackage

// File: rtl/bp_me_cache_dma_to_cce_sipo.sv
// Serial-in parallel-out collector: beat k lands in slice k, counter wraps after the last beat.
module bp_me_cache_dma_to_cce_sipo
   #(parameter int unsigned width_p = 64
   , parameter int unsigned els_p   = 8
   )
   (input  logic                           clk_i
   , input  logic                          reset_i
   , input  logic                          v_i
   , input  logic [width_p-1:0]            data_i
   , output logic [els_p-1:0][width_p-1:0] data_o
   , output logic                          last_o
   );

   localparam int unsigned cnt_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic [cnt_width_lp-1:0]         cnt_q;
   logic [els_p-1:0][width_p-1:0]   data_q;

   assign last_o = v_i && (cnt_q == cnt_width_lp'(els_p - 1));
   assign data_o = data_q;

   // Beat counter; a reset discards any partially collected block.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         cnt_q <= '0;
      else if (v_i)
         cnt_q <= last_o ? '0 : cnt_q + cnt_width_lp'(1);
   end

   // Beat storage, deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (v_i)
         data_q[cnt_q] <= data_i;
   end

endmodule

// File: rtl/bp_me_cache_dma_to_cce.sv
// Adapter between bsg_cache DMA (beat-serial) and BedRock mem (block) interfaces, one transaction at a time.
module bp_me_cache_dma_to_cce
   import bp_me_cache_dma_to_cce_pkg::*;
   #(parameter logic [lce_id_width_gp-1:0] lce_id_p = '0)
   (input  logic                          clk_i
   , input  logic                         reset_i

   , input  logic [dma_pkt_width_gp-1:0]  dma_pkt_i
   , input  logic                         dma_pkt_v_i
   , output logic                         dma_pkt_yumi_o

   , output logic [dword_width_gp-1:0]    dma_data_o
   , output logic                         dma_data_v_o
   , input  logic                         dma_data_ready_i

   , input  logic [dword_width_gp-1:0]    dma_data_i
   , input  logic                         dma_data_v_i
   , output logic                         dma_data_yumi_o

   , output logic [mem_msg_width_gp-1:0]  mem_cmd_o
   , output logic                         mem_cmd_v_o
   , input  logic                         mem_cmd_ready_i

   , input  logic [mem_msg_width_gp-1:0]  mem_resp_i
   , input  logic                         mem_resp_v_i
   , output logic                         mem_resp_yumi_o
   );

   typedef enum logic [2:0] {
      e_idle       = 3'd0,
      e_wr_collect = 3'd1,
      e_cmd_send   = 3'd2,
      e_resp_wait  = 3'd3,
      e_rd_stream  = 3'd4
   } state_e;

   localparam bit beats_ok_lp = (beats_gp >= 1) && ((beats_gp & (beats_gp - 1)) == 0);

   bsg_cache_dma_pkt_s       dma_pkt;
   bp_bedrock_cce_mem_msg_s  mem_cmd;
   bp_bedrock_cce_mem_msg_s  mem_resp;

   state_e                                   state_q;
   logic                                     wnr_q;
   logic [paddr_width_gp-1:0]                addr_q;
   logic [beat_cnt_width_gp-1:0]             rd_cnt_q;
   logic [beats_gp-1:0][dword_width_gp-1:0]  rd_block_q;

   logic                                     evict_v;
   logic                                     evict_last;
   logic [beats_gp-1:0][dword_width_gp-1:0]  evict_block;

   assign dma_pkt  = dma_pkt_i;
   assign mem_resp = mem_resp_i;

   // Handshake strobes; all forced low while reset is asserted.
   assign dma_pkt_yumi_o  = ~reset_i & (state_q == e_idle) & dma_pkt_v_i;
   assign evict_v         = ~reset_i & (state_q == e_wr_collect) & dma_data_v_i;
   assign dma_data_yumi_o = evict_v;
   assign mem_resp_yumi_o = ~reset_i & (state_q == e_resp_wait) & mem_resp_v_i;

   assign mem_cmd_v_o  = (state_q == e_cmd_send);
   assign dma_data_v_o = (state_q == e_rd_stream);
   assign dma_data_o   = rd_block_q[rd_cnt_q];

   // Evict beats are gathered into a full block ahead of the write command.
   bp_me_cache_dma_to_cce_sipo
      #(.width_p(dword_width_gp)
       ,.els_p  (beats_gp)
       )
      evict_sipo
       (.clk_i  (clk_i)
       ,.reset_i(reset_i)
       ,.v_i    (evict_v)
       ,.data_i (dma_data_i)
       ,.data_o (evict_block)
       ,.last_o (evict_last)
       );

   // Command is built purely from latched state, so it holds steady while valid.
   always_comb begin
      mem_cmd                        = '0;
      mem_cmd.header.msg_type        = wnr_q ? e_bedrock_mem_wr : e_bedrock_mem_rd;
      mem_cmd.header.addr            = addr_q;
      mem_cmd.header.size            = e_bedrock_msg_size_64;
      mem_cmd.header.payload.lce_id  = lce_id_p;
      mem_cmd.data                   = wnr_q ? cce_block_width_gp'(evict_block) : '0;
   end
   assign mem_cmd_o = mem_cmd;

   // Transaction sequencer: accept, collect, send, await response, stream fill.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= e_idle;
         wnr_q    <= 1'b0;
         addr_q   <= '0;
         rd_cnt_q <= '0;
      end else begin
         case (state_q)
            e_idle: begin
               if (dma_pkt_v_i) begin
                  wnr_q   <= dma_pkt.write_not_read;
                  addr_q  <= block_align(dma_pkt.addr);
                  state_q <= dma_pkt.write_not_read ? e_wr_collect : e_cmd_send;
               end
            end
            e_wr_collect: begin
               if (evict_last)
                  state_q <= e_cmd_send;
            end
            e_cmd_send: begin
               if (mem_cmd_ready_i)
                  state_q <= e_resp_wait;
            end
            e_resp_wait: begin
               if (mem_resp_v_i)
                  state_q <= wnr_q ? e_idle : e_rd_stream;
            end
            e_rd_stream: begin
               if (dma_data_ready_i) begin
                  if (rd_cnt_q == beat_cnt_width_gp'(beats_gp - 1)) begin
                     rd_cnt_q <= '0;
                     state_q  <= e_idle;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + beat_cnt_width_gp'(1);
                  end
               end
            end
            default: state_q <= e_idle;
         endcase
      end
   end

   // Fill block captured from the read response, deliberately not reset.
   always_ff @(posedge clk_i) begin
      if ((state_q == e_resp_wait) && mem_resp_v_i && !wnr_q)
         rd_block_q <= mem_resp.data;
   end

   // Response header fields are only consulted by the checks below.
   logic unused_resp_hdr;
   assign unused_resp_hdr = ^mem_resp.header;

   // A consumed response must answer the command that was issued.
   assert property (@(posedge clk_i) disable iff (reset_i)
      mem_resp_yumi_o |-> (mem_resp.header.msg_type == mem_cmd.header.msg_type));
   assert property (@(posedge clk_i) disable iff (reset_i)
      mem_resp_yumi_o |-> (mem_resp.header.addr == addr_q));
   assert property (@(posedge clk_i) beats_ok_lp);

endmodule

// File: tb/tb_bp_me_cache_dma_to_cce.sv
// Randomized self-checking bench: reference model computes expected commands and fill beats.
module tb_bp_me_cache_dma_to_cce;
   import bp_me_cache_dma_to_cce_pkg::*;

   localparam int unsigned CW = mem_msg_width_gp;
   localparam int unsigned AW = paddr_width_gp;
   localparam int unsigned BW = cce_block_width_gp;
   localparam int unsigned DW = dword_width_gp;
   localparam int unsigned NB = BW / DW;

   logic                   clk_i = 1'b0;
   logic                   reset_i;
   logic [dma_pkt_width_gp-1:0] dma_pkt_i;
   logic                   dma_pkt_v_i;
   logic                   dma_pkt_yumi_o;
   logic [DW-1:0]          dma_data_o;
   logic                   dma_data_v_o;
   logic                   dma_data_ready_i;
   logic [DW-1:0]          dma_data_i;
   logic                   dma_data_v_i;
   logic                   dma_data_yumi_o;
   logic [CW-1:0]          mem_cmd_o;
   logic                   mem_cmd_v_o;
   logic                   mem_cmd_ready_i;
   logic [CW-1:0]          mem_resp_i;
   logic                   mem_resp_v_i;
   logic                   mem_resp_yumi_o;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk_i = ~clk_i;

   bp_me_cache_dma_to_cce #(.lce_id_p('0)) dut
      (.clk_i           (clk_i)
      ,.reset_i         (reset_i)
      ,.dma_pkt_i       (dma_pkt_i)
      ,.dma_pkt_v_i     (dma_pkt_v_i)
      ,.dma_pkt_yumi_o  (dma_pkt_yumi_o)
      ,.dma_data_o      (dma_data_o)
      ,.dma_data_v_o    (dma_data_v_o)
      ,.dma_data_ready_i(dma_data_ready_i)
      ,.dma_data_i      (dma_data_i)
      ,.dma_data_v_i    (dma_data_v_i)
      ,.dma_data_yumi_o (dma_data_yumi_o)
      ,.mem_cmd_o       (mem_cmd_o)
      ,.mem_cmd_v_o     (mem_cmd_v_o)
      ,.mem_cmd_ready_i (mem_cmd_ready_i)
      ,.mem_resp_i      (mem_resp_i)
      ,.mem_resp_v_i    (mem_resp_v_i)
      ,.mem_resp_yumi_o (mem_resp_yumi_o)
      );

   task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return {8'($urandom_range(0, 255)), 32'($urandom)};
   endfunction

   function automatic logic [BW-1:0] rand_block();
      logic [BW-1:0] b;
      for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   // Expected BedRock message: block address is the request address rounded down to 64 bytes.
   function automatic logic [CW-1:0] make_msg(input logic wnr, input logic [AW-1:0] addr,
                                              input logic [BW-1:0] data);
      bp_bedrock_cce_mem_msg_s m;
      m = '0;
      m.header.msg_type       = wnr ? e_bedrock_mem_wr : e_bedrock_mem_rd;
      m.header.addr           = (addr / AW'(64)) * AW'(64);
      m.header.size           = e_bedrock_msg_size_64;
      m.header.payload.lce_id = '0;
      m.data                  = data;
      return m;
   endfunction

   task automatic send_pkt(input logic wnr, input logic [AW-1:0] addr);
      dma_pkt_i   = {wnr, addr};
      dma_pkt_v_i = 1'b1;
      #1;
      chk("pkt_yumi", CW'(dma_pkt_yumi_o), CW'(1));
      step();
      dma_pkt_v_i = 1'b0;
   endtask

   // Command held for 'stall' cycles, then handshaken together with an offered response.
   task automatic cmd_phase(input logic [CW-1:0] exp_cmd, input int stall, input logic [CW-1:0] resp);
      for (int s = 0; s <= stall; s++) begin
         mem_cmd_ready_i = (s == stall);
         mem_resp_v_i    = (s == stall);
         mem_resp_i      = resp;
         dma_data_v_i    = 1'b1;
         dma_data_i      = {$urandom, $urandom};
         #1;
         chk("cmd_v", CW'(mem_cmd_v_o), CW'(1));
         chk("cmd_msg", mem_cmd_o, exp_cmd);
         chk("stray_evict_yumi", CW'(dma_data_yumi_o), CW'(0));
         chk("resp_yumi_in_cmd", CW'(mem_resp_yumi_o), CW'(0));
         step();
      end
      mem_cmd_ready_i = 1'b0;
      dma_data_v_i    = 1'b0;
      #1;
      chk("cmd_v_drop", CW'(mem_cmd_v_o), CW'(0));
      chk("resp_yumi", CW'(mem_resp_yumi_o), CW'(1));
      step();
      mem_resp_v_i = 1'b0;
   endtask

   // mode 0: always ready, 1: toggling ready, 2: random ready.
   task automatic read_body(input logic [AW-1:0] addr, input logic [BW-1:0] blk, input int stall,
                            input int mode, input bit hold_next, input logic [AW-1:0] next_addr);
      logic [DW-1:0] exp_q[$];
      int  idx, cyc;
      logic rdy;
      for (int k = 0; k < NB; k++) exp_q.push_back(blk[k*DW +: DW]);
      cmd_phase(make_msg(1'b0, addr, '0), stall, make_msg(1'b0, addr, blk));
      idx = 0;
      cyc = 0;
      while (idx < NB && cyc < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         dma_data_ready_i = rdy;
         if (hold_next) begin
            dma_pkt_i   = {1'b0, next_addr};
            dma_pkt_v_i = 1'b1;
         end
         #1;
         if (hold_next) chk("busy_pkt_yumi", CW'(dma_pkt_yumi_o), CW'(0));
         chk("fill_v", CW'(dma_data_v_o), CW'(1));
         if (dma_data_v_o && rdy) begin
            chk("fill_beat", CW'(dma_data_o), CW'(exp_q[idx]));
            idx++;
         end
         step();
         cyc++;
      end
      dma_data_ready_i = 1'b0;
      chk("fill_count", CW'(idx), CW'(NB));
      #1;
      chk("fill_done_v", CW'(dma_data_v_o), CW'(0));
      if (hold_next) chk("pkt_after_busy", CW'(dma_pkt_yumi_o), CW'(1));
      step();
      dma_pkt_v_i = 1'b0;
   endtask

   task automatic write_body(input logic [AW-1:0] addr, input logic [BW-1:0] blk, input int stall,
                             input bit early);
      int  idx, cyc;
      logic v;
      idx = 0;
      cyc = 0;
      while (idx < NB && cyc < 400) begin
         v            = ($urandom_range(0, 3) != 0);
         dma_data_v_i = v;
         dma_data_i   = v ? blk[idx*DW +: DW] : {$urandom, $urandom};
         mem_resp_v_i = early;
         mem_resp_i   = make_msg(1'b1, addr, '0);
         #1;
         if (v) chk("evict_yumi", CW'(dma_data_yumi_o), CW'(1));
         if (early) chk("early_resp_yumi", CW'(mem_resp_yumi_o), CW'(0));
         chk("cmd_v_collect", CW'(mem_cmd_v_o), CW'(0));
         step();
         if (v) idx++;
         cyc++;
      end
      dma_data_v_i = 1'b0;
      mem_resp_v_i = 1'b0;
      cmd_phase(make_msg(1'b1, addr, blk), stall, make_msg(1'b1, addr, '0));
      #1;
      chk("no_fill_after_wr", CW'(dma_data_v_o), CW'(0));
      chk("wr_idle_cmd_v", CW'(mem_cmd_v_o), CW'(0));
      step();
   endtask

   initial begin
      logic [BW-1:0] blk;
      logic [AW-1:0] a, a2;
      bit            wnr;

      reset_i          = 1'b1;
      dma_pkt_i        = '0;
      dma_pkt_v_i      = 1'b1;
      dma_data_ready_i = 1'b0;
      dma_data_i       = '0;
      dma_data_v_i     = 1'b1;
      mem_cmd_ready_i  = 1'b0;
      mem_resp_i       = '0;
      mem_resp_v_i     = 1'b1;
      step();
      step();
      chk("rst_pkt_yumi", CW'(dma_pkt_yumi_o), CW'(0));
      chk("rst_evict_yumi", CW'(dma_data_yumi_o), CW'(0));
      chk("rst_resp_yumi", CW'(mem_resp_yumi_o), CW'(0));
      chk("rst_cmd_v", CW'(mem_cmd_v_o), CW'(0));
      chk("rst_fill_v", CW'(dma_data_v_o), CW'(0));
      dma_pkt_v_i  = 1'b0;
      dma_data_v_i = 1'b0;
      mem_resp_v_i = 1'b0;
      reset_i      = 1'b0;
      step();

      // Directed read fill: beats come back lowest slice first.
      for (int k = 0; k < NB; k++) blk[k*DW +: DW] = {32'hDA7A_0000 + 32'(k), 32'(k)};
      send_pkt(1'b0, 40'h00_8000_0040);
      read_body(40'h00_8000_0040, blk, 0, 0, 1'b0, '0);

      // Directed write evict with an early response offered during collection.
      for (int k = 0; k < NB; k++) blk[k*DW +: DW] = 64'h11 * 64'(k + 1);
      send_pkt(1'b1, 40'h00_8000_1008);
      write_body(40'h00_8000_1008, blk, 0, 1'b1);

      // Backpressure and busy: command stalled, toggling fill ready, second request held.
      a  = rand_addr();
      a2 = rand_addr();
      send_pkt(1'b0, a);
      read_body(a, rand_block(), 5, 1, 1'b1, a2);
      read_body(a2, rand_block(), 2, 2, 1'b0, '0);

      // Random mix.
      for (int t = 0; t < 12; t++) begin
         wnr = 1'($urandom_range(0, 1));
         a   = rand_addr();
         send_pkt(wnr, a);
         if (wnr) write_body(a, rand_block(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         else     read_body(a, rand_block(), $urandom_range(0, 3), 2, 1'b0, '0);
      end

      // Asynchronous reset in the middle of evict collection.
      a = rand_addr();
      send_pkt(1'b1, a);
      for (int k = 0; k < 3; k++) begin
         dma_data_v_i = 1'b1;
         dma_data_i   = {$urandom, $urandom};
         step();
      end
      dma_pkt_v_i  = 1'b1;
      mem_resp_v_i = 1'b1;
      #1;
      reset_i = 1'b1;
      #1;
      chk("mid_rst_evict_yumi", CW'(dma_data_yumi_o), CW'(0));
      chk("mid_rst_pkt_yumi", CW'(dma_pkt_yumi_o), CW'(0));
      chk("mid_rst_resp_yumi", CW'(mem_resp_yumi_o), CW'(0));
      chk("mid_rst_cmd_v", CW'(mem_cmd_v_o), CW'(0));
      chk("mid_rst_fill_v", CW'(dma_data_v_o), CW'(0));
      step();
      step();
      dma_data_v_i = 1'b0;
      dma_pkt_v_i  = 1'b0;
      mem_resp_v_i = 1'b0;
      reset_i      = 1'b0;
      step();
      a = rand_addr();
      send_pkt(1'b0, a);
      read_body(a, rand_block(), 1, 0, 1'b0, '0);
      a = rand_addr();
      send_pkt(1'b1, a);
      write_body(a, rand_block(), 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
